// File: rtl/itype_pkg.sv
// Shared opcodes, instruction field positions and fetch FSM encoding for the
// I-type fetch/issue front end.
package itype_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STALL  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

  // Opcodes that never reach the I-type execute unit when filtering is built in.
  function automatic logic is_filtered_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/itype_fetch_issue_fifo.sv
// Prefetch FIFO: DEPTH entries of {instruction, pc}, synchronous flush,
// power-of-2 pointers that wrap naturally, occupancy count output.
module itype_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_flush,
  input  logic           i_wr_en,
  input  logic [W-1:0]   i_wr_data,
  input  logic           i_rd_en,
  output logic [W-1:0]   o_rd_data,
  output logic [PTR_W:0] o_count,
  output logic           o_empty
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (i_rd_en) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(i_wr_en) - (PTR_W+1)'(i_rd_en);
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/itype_fetch_issue.sv
// I-type fetch/issue front end: PC walker, 1-cycle imem interface, prefetch FIFO,
// branch redirect and HALT stop. Optional ITYPE_FILTER_EN drops R/J/JAL words.
module itype_fetch_issue
  import itype_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted,
  output logic [1:0]        o_dbg_state
`ifdef ITYPE_FILTER_EN
  ,
  output logic [7:0]        drop_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = 32 + ADDR_W;

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_infl_pc;
  logic              r_infl;
  logic              r_halted;

  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic [ENT_W-1:0]  w_head;
  logic              w_room;
  logic              w_ret_halt;
  logic              w_req;
  logic              w_drop;
  logic              w_enq;
  logic              w_deq;
  logic [ADDR_W-1:0] w_target;

  // Slots are reserved at request time: a request goes out only if the word it
  // returns is guaranteed a FIFO entry, so enqueue never sees a full FIFO.
  assign w_room     = ({1'b0, w_count} + (CNT_W+1)'(r_infl)) < (CNT_W+1)'(DEPTH);
  assign w_ret_halt = r_infl && (opcode_of(imem_rdata) == OP_HALT);
  assign w_req      = (r_state == ST_FETCH) && w_room && !w_ret_halt;
  assign w_target   = branch_target & ~ADDR_W'(3);

`ifdef ITYPE_FILTER_EN
  assign w_drop = r_infl && is_filtered_op(opcode_of(imem_rdata));
`else
  assign w_drop = 1'b0;
`endif

  // Handshake: instr_valid is the registered FIFO-not-empty flag and never looks
  // at instr_ready; a word transfers on valid & ready, and data/pc hold while
  // valid & !ready because the head entry only moves on a transfer or a flush.
  assign w_enq = r_infl && !branch_taken && !w_drop;
  assign w_deq = instr_valid && instr_ready;

  itype_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_flush   (branch_taken),
    .i_wr_en   (w_enq),
    .i_wr_data ({imem_rdata, r_infl_pc}),
    .i_rd_en   (w_deq),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_infl_pc <= '0;
      r_infl    <= 1'b0;
      r_halted  <= 1'b0;
    end else if (branch_taken) begin
      // Redirect squashes both the returning word and any request made this cycle.
      r_state  <= ST_FETCH;
      r_pc     <= w_target;
      r_infl   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_infl <= w_req;
      if (w_req) begin
        r_infl_pc <= r_pc;
        r_pc      <= r_pc + ADDR_W'(4);
      end
      if (w_ret_halt) begin
        r_state  <= ST_HALTED;
        r_halted <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE:   r_state <= ST_FETCH;
          ST_FETCH:  if (!w_room) r_state <= ST_STALL;
          ST_STALL:  if (w_room) r_state <= ST_FETCH;
          default:   r_state <= ST_HALTED;
        endcase
      end
    end
  end

`ifdef ITYPE_FILTER_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drop_count <= 8'h00;
    end else if (w_drop && !branch_taken && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'h01;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr_data  = w_head[ENT_W-1:ADDR_W];
  assign instr_pc    = w_head[ADDR_W-1:0];
  assign halted      = r_halted;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_itype_fetch_issue.sv
// Directed bench for itype_fetch_issue: reset, streaming, backpressure, branch,
// HALT, async reset and (with ITYPE_FILTER_EN) opcode filtering.
module tb_itype_fetch_issue;
  import itype_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        halted;
  logic [1:0]  dbg_state;
`ifdef ITYPE_FILTER_EN
  logic [7:0]  drop_count;
`endif

  itype_fetch_issue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halted        (halted),
    .o_dbg_state   (dbg_state)
`ifdef ITYPE_FILTER_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  // ---------------- memory model and request log ----------------
  logic [31:0] mem [1024];
  logic [31:0] req_q [$];
  logic [31:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clock) if (imem_req) imem_rdata <= mem[imem_addr[11:2]];
  always @(negedge clock) if (imem_req) req_q.push_back(imem_addr);

  function automatic logic [31:0] addi_word(input int unsigned addr);
    return {OP_ADDI, 26'(addr)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = addi_word(i * 4);
  endtask

  // Leaves time at posedge+1 with reset just released; the next edge is E1.
  task automatic start_dut();
    branch_taken = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    req_q.delete();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_tests++; if (instr_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", instr_data); end
    n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", instr_pc); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", dbg_state); end
  endtask

  task automatic test_fetch();
    fill_mem();
    instr_ready = 1'b1;
    start_dut();
    tick();
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_e1_valid got %b want 0", instr_valid); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL fetch_e1_req got %b/%h want 1/0", imem_req, imem_addr); end
    tick();
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_e2_valid got %b want 0", instr_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4) || instr_data !== addi_word(k * 4)) begin
        n_fail++;
        $display("FAIL fetch_stream[%0d] got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                 k, instr_valid, instr_pc, instr_data, 32'(k * 4), addi_word(k * 4));
      end
    end
  endtask

  task automatic test_backpressure();
    fill_mem();
    instr_ready = 1'b0;
    start_dut();
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c >= 3) begin
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== addi_word(0)) begin
          n_fail++;
          $display("FAIL bp_hold[%0d] got v=%b pc=%h d=%h want v=1 pc=0 d=%h", c, instr_valid, instr_pc, instr_data, addi_word(0));
        end
      end
    end
    n_tests++; if (req_q.size() != DEPTH) begin n_fail++; $display("FAIL bp_req_count got %0d want %0d", req_q.size(), DEPTH); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_low got %b want 0", imem_req); end
    n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL bp_state got %0d want 2", dbg_state); end
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(k * 4));
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_pc;
      exp_pc = exp_q.pop_front();
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin
        n_fail++;
        $display("FAIL bp_drain[%0d] got v=%b pc=%h want v=1 pc=%h", k, instr_valid, instr_pc, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    fill_mem();
    instr_ready = 1'b0;
    start_dut();
    repeat (5) tick();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL br_pre got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
    branch_taken  = 1'b1;
    branch_target = 32'h42;
    instr_ready   = 1'b1;
    tick();
    branch_taken = 1'b0;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush got v=%b want 0", instr_valid); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_req got %b/%h want 1/40", imem_req, imem_addr); end
    tick();
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_gap got v=%b want 0", instr_valid); end
    tick();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_data !== addi_word(32'h40)) begin n_fail++; $display("FAIL br_target got v=%b pc=%h d=%h want v=1 pc=40", instr_valid, instr_pc, instr_data); end
    tick();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h44) begin n_fail++; $display("FAIL br_next got v=%b pc=%h want v=1 pc=44", instr_valid, instr_pc); end
  endtask

  task automatic test_halt();
    logic bad_req;
    fill_mem();
    mem[4] = 32'hFC000000;
    instr_ready = 1'b1;
    start_dut();
    repeat (6) tick();
    n_tests++; if (halted !== 1'b0 || instr_pc !== 32'hC) begin n_fail++; $display("FAIL halt_pre got h=%b pc=%h want h=0 pc=c", halted, instr_pc); end
    tick();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr_data !== 32'hFC000000) begin n_fail++; $display("FAIL halt_issue got v=%b pc=%h d=%h want v=1 pc=10 d=fc000000", instr_valid, instr_pc, instr_data); end
    n_tests++; if (halted !== 1'b1 || dbg_state !== 2'd3) begin n_fail++; $display("FAIL halt_flag got h=%b st=%0d want h=1 st=3", halted, dbg_state); end
    repeat (4) tick();
    n_tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_idle got v=%b req=%b h=%b want 0/0/1", instr_valid, imem_req, halted); end
    bad_req = 1'b0;
    foreach (req_q[i]) if (req_q[i] >= 32'h14) bad_req = 1'b1;
    n_tests++; if (bad_req !== 1'b0) begin n_fail++; $display("FAIL halt_no_req got request past halt=%b want 0", bad_req); end
    branch_taken  = 1'b1;
    branch_target = 32'h0;
    tick();
    branch_taken = 1'b0;
    n_tests++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL halt_resume got h=%b req=%b a=%h want 0/1/0", halted, imem_req, imem_addr); end
    repeat (2) tick();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL halt_refetch got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
  endtask

  task automatic test_async_reset();
    fill_mem();
    instr_ready = 1'b1;
    start_dut();
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_pc !== 32'h0 || instr_data !== 32'h0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_outputs got v=%b req=%b a=%h pc=%h d=%h h=%b want all 0",
               instr_valid, imem_req, imem_addr, instr_pc, instr_data, halted);
    end
    reset = 1'b0;
    req_q.delete();
    tick();
    n_tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL areset_e1 got v=%b req=%b a=%h want 0/1/0", instr_valid, imem_req, imem_addr); end
    tick();
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL areset_e2 got v=%b want 0", instr_valid); end
    tick();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== addi_word(0)) begin n_fail++; $display("FAIL areset_first got v=%b pc=%h d=%h want v=1 pc=0", instr_valid, instr_pc, instr_data); end
  endtask

`ifdef ITYPE_FILTER_EN
  task automatic test_filter();
    fill_mem();
    mem[0] = {OP_RTYPE, 26'h1};
    mem[1] = {OP_J, 26'h4};
    mem[3] = 32'hFC000000;
    instr_ready = 1'b1;
    start_dut();
    n_tests++; if (drop_count !== 8'h00) begin n_fail++; $display("FAIL filt_reset got %h want 00", drop_count); end
    repeat (4) tick();
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL filt_gap got v=%b want 0", instr_valid); end
    tick();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr_data !== addi_word(8)) begin n_fail++; $display("FAIL filt_issue got v=%b pc=%h d=%h want v=1 pc=8", instr_valid, instr_pc, instr_data); end
    n_tests++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL filt_count got %0d want 2", drop_count); end
    tick();
    n_tests++; if (instr_pc !== 32'hC || halted !== 1'b1) begin n_fail++; $display("FAIL filt_halt got pc=%h h=%b want c/1", instr_pc, halted); end
    for (int i = 0; i < 300; i++) mem[64 + i] = {OP_RTYPE, 26'(i)};
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    repeat (150) tick();
    n_tests++; if (drop_count !== 8'd151 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL filt_mid got cnt=%0d v=%b want 151/0", drop_count, instr_valid); end
    repeat (200) tick();
    n_tests++; if (drop_count !== 8'hFF) begin n_fail++; $display("FAIL filt_sat got %h want ff", drop_count); end
  endtask
`else
  task automatic test_no_filter();
    fill_mem();
    mem[0] = {OP_RTYPE, 26'h123};
    mem[1] = {OP_J, 26'h456};
    instr_ready = 1'b1;
    start_dut();
    repeat (3) tick();
    n_tests++; if (instr_pc !== 32'h0 || instr_data !== {OP_RTYPE, 26'h123}) begin n_fail++; $display("FAIL nofilt_r got pc=%h d=%h want 0/%h", instr_pc, instr_data, {OP_RTYPE, 26'h123}); end
    tick();
    n_tests++; if (instr_pc !== 32'h4 || instr_data !== {OP_J, 26'h456}) begin n_fail++; $display("FAIL nofilt_j got pc=%h d=%h want 4/%h", instr_pc, instr_data, {OP_J, 26'h456}); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_branch();
    test_halt();
    test_async_reset();
`ifdef ITYPE_FILTER_EN
    test_filter();
`else
    test_no_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
